// File: rtl/way3_err_monitor_if.sv
// Control, flag and status bundle between a voter-bank supervisor and its user.
// SEU_MON_TIMESTAMP_EN adds the ts_o timestamp signal.
interface way3_err_monitor_if #(
  parameter int N  = 4,
  parameter int CW = 16
);
  localparam int IW = $clog2(N);

  logic          en_i;
  logic          clear_i;
  logic [N-1:0]  error1_i;
  logic [N-1:0]  error2_i;
  logic [1:0]    state_o;
  logic          irq_o;
  logic [CW-1:0] cnt_e1_o;
  logic [CW-1:0] cnt_e2_o;
  logic [IW-1:0] first_idx_o;
`ifdef SEU_MON_TIMESTAMP_EN
  logic [31:0]   ts_o;

  modport master (output en_i, clear_i, error1_i, error2_i,
                  input  state_o, irq_o, cnt_e1_o, cnt_e2_o, first_idx_o, ts_o);
  modport slave  (input  en_i, clear_i, error1_i, error2_i,
                  output state_o, irq_o, cnt_e1_o, cnt_e2_o, first_idx_o, ts_o);
`else
  modport master (output en_i, clear_i, error1_i, error2_i,
                  input  state_o, irq_o, cnt_e1_o, cnt_e2_o, first_idx_o);
  modport slave  (input  en_i, clear_i, error1_i, error2_i,
                  output state_o, irq_o, cnt_e1_o, cnt_e2_o, first_idx_o);
`endif
endinterface

// File: rtl/way3_err_monitor.sv
// Error supervisor for a bank of N three-way voters: flag registers, saturating event
// counters, persistence detection and sticky irq. SEU_MON_TIMESTAMP_EN adds a cycle timestamp.
module way3_err_monitor #(
  parameter int N       = 4,
  parameter int CW      = 16,
  parameter int PERSIST = 8
) (
  input logic           clk_i,
  input logic           rst_i,
  way3_err_monitor_if.slave mon
);
  localparam int IW = $clog2(N);
  localparam logic [1:0]    S_OK    = 2'b00;
  localparam logic [1:0]    S_TRANS = 2'b01;
  localparam logic [1:0]    S_PERS  = 2'b10;
  localparam logic [1:0]    S_FATAL = 2'b11;
  localparam logic [CW-1:0] CMAX    = '1;
  localparam logic [CW-1:0] PERS_C  = CW'(PERSIST);
  localparam logic [CW-1:0] ONE     = CW'(1);

  logic [N-1:0]  e1_q, e2_q;
  logic          a1, a2, leave_ok;
  logic [1:0]    state_q, state_b, state_n;
  logic [CW-1:0] run_q, run_b, run_n;
  logic [CW-1:0] c1_q, c1_b, c1_n;
  logic [CW-1:0] c2_q, c2_b, c2_n;
  logic [IW-1:0] idx_q, idx_b, idx_n;

  function automatic logic [IW-1:0] lowest(input logic [N-1:0] v);
    lowest = '0;
    for (int k = N - 1; k >= 0; k--)
      if (v[k]) lowest = IW'(k);
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      e1_q <= '0;
      e2_q <= '0;
    end else begin
      e1_q <= mon.en_i ? mon.error1_i : '0;
      e2_q <= mon.en_i ? mon.error2_i : '0;
    end
  end

  assign a2 = |e2_q;
  assign a1 = (|e1_q) & ~a2;

  // Clear zeroes the base that this cycle's update builds on, so a coincident error survives.
  always_comb begin
    state_b = mon.clear_i ? S_OK : state_q;
    run_b   = mon.clear_i ? '0   : run_q;
    c1_b    = mon.clear_i ? '0   : c1_q;
    c2_b    = mon.clear_i ? '0   : c2_q;
    idx_b   = mon.clear_i ? '0   : idx_q;
  end

  always_comb begin
    run_n = '0;
    if (a1) run_n = (run_b == PERS_C) ? run_b : run_b + ONE;
    c1_n = (a1 && c1_b != CMAX) ? c1_b + ONE : c1_b;
    c2_n = (a2 && c2_b != CMAX) ? c2_b + ONE : c2_b;
  end

  always_comb begin
    state_n = state_b;
    unique case (state_b)
      S_OK:    if (a2) state_n = S_FATAL; else if (a1) state_n = S_TRANS;
      S_TRANS: if (a2) state_n = S_FATAL; else if (run_n == PERS_C) state_n = S_PERS;
      S_PERS:  if (a2) state_n = S_FATAL;
      default: state_n = S_FATAL;
    endcase
  end

  assign leave_ok = (state_b == S_OK) && (state_n != S_OK);
  assign idx_n    = leave_ok ? lowest(a2 ? e2_q : e1_q) : idx_b;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_OK;
      run_q   <= '0;
      c1_q    <= '0;
      c2_q    <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_n;
      run_q   <= run_n;
      c1_q    <= c1_n;
      c2_q    <= c2_n;
      idx_q   <= idx_n;
    end
  end

  always_comb begin
    mon.state_o     = state_q;
    mon.irq_o       = (state_q != S_OK);
    mon.cnt_e1_o    = c1_q;
    mon.cnt_e2_o    = c2_q;
    mon.first_idx_o = idx_q;
  end

`ifdef SEU_MON_TIMESTAMP_EN
  logic [31:0] cyc_q, ts_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cyc_q <= '0;
      ts_q  <= '0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      if (leave_ok)         ts_q <= cyc_q;
      else if (mon.clear_i) ts_q <= '0;
    end
  end

  assign mon.ts_o = ts_q;
`endif
endmodule
